regfile_dump_reader: RTL and testbench

Debug/readout engine that walks every entry of the register file through a dedicated asynchronous read port and streams each word out over a valid/ready handshake. It is the reader counterpart to the core's writeback path. It sits beside the register file, and its RA/RD pair connects to a spare read address/data port. A debug host or testbench starts a dump and receives 2**ADDR_WIDTH words in ascending address order.

---
 rtl/regfile_dump_reader.sv | 132 +++++++++++++
 tb/tb_regfile_dump_reader.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_reader.sv
// Streams every register file entry over a valid/ready port, lowest address first.
// Optional trailing XOR checksum beat when REGDUMP_CHECKSUM_EN is defined.
module regfile_dump_reader #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  START,
    input  logic                  ABORT,
    output logic [ADDR_WIDTH-1:0] RA,
    input  logic [DATA_WIDTH-1:0] RD,
    output logic [DATA_WIDTH-1:0] DOUT,
    output logic [ADDR_WIDTH-1:0] DADDR,
    output logic                  DVALID,
    input  logic                  DREADY,
    output logic                  DLAST,
    output logic                  DCSUM,
    output logic                  BUSY,
    output logic                  DONE
);

    localparam logic [ADDR_WIDTH-1:0] MAX = '1;

`ifdef REGDUMP_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LOAD, SEND, CSUM, CSEND, FIN} state_t;
    logic [DATA_WIDTH-1:0] csum;
`else
    typedef enum logic [1:0] {IDLE, LOAD, SEND, FIN} state_t;
    assign DCSUM = 1'b0;
`endif

    state_t                state;
    logic [ADDR_WIDTH-1:0] cnt;

    // RA comes straight from the counter so RD is settled for the LOAD capture
    assign RA = cnt;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state  <= IDLE;
            cnt    <= '0;
            DOUT   <= '0;
            DADDR  <= '0;
            DVALID <= 1'b0;
            DLAST  <= 1'b0;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            DCSUM  <= 1'b0;
            csum   <= '0;
`endif
        end else if (ABORT && state != IDLE) begin
            state  <= IDLE;
            DVALID <= 1'b0;
            DLAST  <= 1'b0;
            DONE   <= 1'b0;
            BUSY   <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            DCSUM  <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (START) begin
                        cnt   <= '0;
                        BUSY  <= 1'b1;
                        state <= LOAD;
`ifdef REGDUMP_CHECKSUM_EN
                        csum  <= '0;
`endif
                    end
                end
                LOAD: begin
                    DOUT   <= RD;
                    DADDR  <= cnt;
                    DVALID <= 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
                    DLAST  <= 1'b0;
                    csum   <= csum ^ RD;
`else
                    DLAST  <= (cnt == MAX);
`endif
                    state  <= SEND;
                end
                SEND: begin
                    if (DREADY) begin
                        DVALID <= 1'b0;
                        DLAST  <= 1'b0;
                        if (cnt == MAX) begin
`ifdef REGDUMP_CHECKSUM_EN
                            state <= CSUM;
`else
                            DONE  <= 1'b1;
                            state <= FIN;
`endif
                        end else begin
                            cnt   <= cnt + 1'b1;
                            state <= LOAD;
                        end
                    end
                end
`ifdef REGDUMP_CHECKSUM_EN
                CSUM: begin
                    DOUT   <= csum;
                    DADDR  <= '0;
                    DCSUM  <= 1'b1;
                    DLAST  <= 1'b1;
                    DVALID <= 1'b1;
                    state  <= CSEND;
                end
                CSEND: begin
                    if (DREADY) begin
                        DVALID <= 1'b0;
                        DCSUM  <= 1'b0;
                        DLAST  <= 1'b0;
                        DONE   <= 1'b1;
                        state  <= FIN;
                    end
                end
`endif
                FIN: begin
                    DONE  <= 1'b0;
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: reset, full dumps, stalls, abort,
// concurrent write, START while busy, and the optional checksum beat.
module tb_regfile_dump_reader;

`ifdef REGDUMP_CHECKSUM_EN
    localparam int CSB = 1;
`else
    localparam int CSB = 0;
`endif
    localparam int CSX = 2 * CSB;

    logic        CLK;
    logic        RST_N;
    logic        START;
    logic        ABORT;
    logic [4:0]  RA;
    logic [31:0] RD;
    logic [31:0] DOUT;
    logic [4:0]  DADDR;
    logic        DVALID;
    logic        DREADY;
    logic        DLAST;
    logic        DCSUM;
    logic        BUSY;
    logic        DONE;

    logic [31:0] rf [32];
    assign RD = rf[RA];

    int tests = 0;
    int fails = 0;

    regfile_dump_reader #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .ABORT(ABORT),
        .RA(RA), .RD(RD), .DOUT(DOUT), .DADDR(DADDR), .DVALID(DVALID),
        .DREADY(DREADY), .DLAST(DLAST), .DCSUM(DCSUM), .BUSY(BUSY),
        .DONE(DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int          pat;
        int          sb;
        int          sl;
        int          wa;
        int          sbeat;
        int          exp_cyc;
        logic [31:0] exp5;
    } vec_t;

    vec_t vt [7];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fill(input int pat);
        for (int i = 0; i < 32; i++) begin
            if (pat == 0) rf[i] = i * 32'h11111111;
            else if (pat == 2) rf[i] = (i == 3) ? 32'h1 : 32'hA5A5A5A5;
        end
    endtask

    task automatic run_dump(input vec_t v, output logic [31:0] d5,
                            output logic [31:0] dx);
        logic [31:0] snap [32];
        logic [31:0] x;
        logic [38:0] bq [40];
        logic [38:0] e;
        int nb, cyc, left, dcyc;
        bit sdone, wpend, dseen;
        snap = rf;
        x = '0;
        for (int i = 0; i < 32; i++) x ^= snap[i];
        left = v.sl; nb = 0; dcyc = -1;
        sdone = 0; wpend = 0; dseen = 0;
        d5 = '0; dx = '0;
        @(posedge CLK); #1 START = 1'b1; DREADY = 1'b1;
        @(posedge CLK); #1 START = 1'b0;
        cyc = 0;
        while (!dseen && cyc < 300) begin
            DREADY = 1'b1;
            if (DVALID && !DCSUM && int'(DADDR) == v.sb && left > 0) begin
                DREADY = 1'b0;
                left--;
            end
            if (v.sbeat >= 0 && !sdone && DVALID && int'(DADDR) == v.sbeat) begin
                START = 1'b1;
                sdone = 1;
            end else begin
                START = 1'b0;
            end
            wpend = (v.wa >= 0 && BUSY && !DVALID && !DONE && int'(RA) == v.wa);
            #4;
            if (DVALID && DREADY) begin
                if (nb < 40) bq[nb] = {DADDR, DLAST, DCSUM, DOUT};
                nb++;
            end
            if (DVALID && !DREADY)
                chk("stall_hold", {DVALID, DADDR, DOUT}, {1'b1, 5'(v.sb), snap[v.sb]});
            if (DONE) begin
                dseen = 1;
                dcyc = cyc;
                chk("fin_busy", 64'(BUSY), 64'd1);
            end
            @(posedge CLK);
            if (wpend) rf[v.wa] <= 32'hDEADBEEF;
            cyc++;
            #1;
        end
        START = 1'b0;
        chk("done_cycle", 64'(dcyc), 64'(v.exp_cyc));
        chk("after_fin", {BUSY, DONE, DVALID}, 3'b000);
        @(posedge CLK); #1;
        chk("idle_quiet", {BUSY, DONE, DVALID}, 3'b000);
        chk("beat_count", 64'(nb), 64'(32 + CSB));
        for (int i = 0; i < nb && i < 40; i++) begin
            if (i < 32) e = {5'(i), (i == 31 && CSB == 0), 1'b0, snap[i]};
            else e = {5'd0, 1'b1, 1'b1, x};
            chk($sformatf("beat%0d", i), bq[i], e);
        end
        if (nb > 5) d5 = bq[5][31:0];
        if (nb > 32) dx = bq[32][31:0];
    endtask

    logic [31:0] d5, dx;
    vec_t        va;

    initial begin
        vt[0] = '{0, -1, 0, -1, -1, 64 + CSX, 32'h55555555};
        vt[1] = '{0,  7, 5, -1, -1, 69 + CSX, 32'h55555555};
        vt[2] = '{0,  0, 3, -1, -1, 67 + CSX, 32'h55555555};
        vt[3] = '{0, -1, 0,  5, -1, 64 + CSX, 32'h55555555};
        vt[4] = '{1, -1, 0, -1, -1, 64 + CSX, 32'hDEADBEEF};
        vt[5] = '{0, -1, 0, -1, 10, 64 + CSX, 32'h55555555};
        vt[6] = '{2, 31, 2, -1, -1, 66 + CSX, 32'hA5A5A5A5};

        RST_N = 1'b0; START = 1'b0; ABORT = 1'b0; DREADY = 1'b1;
        fill(0);
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_ra", 64'(RA), 64'd0);
        chk("rst_dout", 64'(DOUT), 64'd0);
        chk("rst_daddr", 64'(DADDR), 64'd0);
        chk("rst_flags", {DVALID, DLAST, DCSUM, BUSY, DONE}, 5'b0);
        RST_N = 1'b1;

        for (int k = 0; k < 7; k++) begin
            fill(vt[k].pat);
            run_dump(vt[k], d5, dx);
            chk($sformatf("vec%0d_word5", k), 64'(d5), 64'(vt[k].exp5));
`ifdef REGDUMP_CHECKSUM_EN
            if (vt[k].pat == 2) chk("csum_value", 64'(dx), 64'hA5A5A5A4);
`endif
        end

        fill(0);
        @(posedge CLK); #1 START = 1'b1; DREADY = 1'b1;
        @(posedge CLK); #1 START = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (DVALID && DADDR == 5'd12) break;
            @(posedge CLK); #1;
        end
        chk("abort_at12", {DVALID, DADDR}, {1'b1, 5'd12});
        ABORT = 1'b1;
        @(posedge CLK); #1 ABORT = 1'b0;
        chk("abort_idle", {DVALID, DLAST, DCSUM, DONE, BUSY}, 5'b0);
        for (int c = 0; c < 4; c++) begin
            @(posedge CLK); #1;
            chk("abort_nodone", {DONE, DVALID, BUSY}, 3'b000);
        end

        ABORT = 1'b1;
        @(posedge CLK); #1 ABORT = 1'b0;
        chk("abort_in_idle", {BUSY, DVALID}, 2'b00);

        va = '{0, -1, 0, -1, -1, 64 + CSX, 32'h55555555};
        run_dump(va, d5, dx);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
